// File: rtl/tt_func_eval_if.sv
// Stream and config-port bundle for the truth-table function unit.
// master = the block driving vectors and table bits, slave = tt_func_eval.
interface tt_func_eval_if #(
    parameter int N_IN = 4
);
    logic            cfg_start;
    logic            cfg_valid;
    logic            cfg_bit;
    logic            cfg_busy;
    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] in_vec;
    logic            out_valid;
    logic            out_ready;
    logic            out_f;
    logic [N_IN-1:0] out_vec;

    modport master (
        output cfg_start, cfg_valid, cfg_bit, in_valid, in_vec, out_ready,
        input  cfg_busy, in_ready, out_valid, out_f, out_vec
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_bit, in_valid, in_vec, out_ready,
        output cfg_busy, in_ready, out_valid, out_f, out_vec
    );
endinterface

// File: rtl/tt_func_eval.sv
// N-input Boolean function unit: a run-time loadable truth table evaluated
// through a one-deep valid/ready slice, with a saturating count of 1 results.
module tt_func_eval #(
    parameter int                      N_IN       = 4,
    parameter logic [(2**N_IN)-1:0]    DEFAULT_TT = 16'hB0A0,
    parameter int                      CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    tt_func_eval_if.slave      bus,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   hit_cnt
);
    localparam int TT_W = 2**N_IN;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t          state_q, state_d;
    logic [TT_W-1:0] active_tt;
    logic [TT_W-1:0] shadow;
    logic [TT_W-1:0] shadow_next;
    logic [N_IN-1:0] bit_idx;
    logic            shift_en;
    logic            commit;
    logic            idx_clr;

    logic            out_valid_q;
    logic            out_f_q;
    logic [N_IN-1:0] out_vec_q;
    logic            accept;
    logic            hit;

    // Minterm 0 arrives first, so bits shift in from the top and settle at index 0.
    assign shadow_next = {bus.cfg_bit, shadow[TT_W-1:1]};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        commit   = 1'b0;
        idx_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cfg_start) begin
                    state_d = LOAD;
                    idx_clr = 1'b1;
                end
            end
            LOAD: begin
                if (bus.cfg_valid) begin
                    shift_en = 1'b1;
                    if (bit_idx == {N_IN{1'b1}}) begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: the table is a plain register, not a RAM, so it can and must take a reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_tt <= DEFAULT_TT;
            shadow    <= '0;
            bit_idx   <= '0;
        end else begin
            if (idx_clr)       bit_idx <= '0;
            else if (shift_en) bit_idx <= bit_idx + N_IN'(1);
            if (shift_en)      shadow    <= shadow_next;
            if (commit)        active_tt <= shadow_next;
        end
    end

    assign bus.cfg_busy = (state_q == LOAD);

    assign bus.in_ready = !out_valid_q | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;

    // A vector accepted on the commit edge still reads the pre-commit table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_f_q     <= 1'b0;
            out_vec_q   <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_f_q     <= active_tt[bus.in_vec];
            out_vec_q   <= bus.in_vec;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_f     = out_f_q;
    assign bus.out_vec   = out_vec_q;

    assign hit = out_valid_q & bus.out_ready & out_f_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              hit_cnt <= '0;
        else if (cnt_clr)                     hit_cnt <= '0;
        else if (hit && (hit_cnt != '1))      hit_cnt <= hit_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_tt_func_eval.sv
// Self-checking bench: a behavioural model for the default build plus
// directed checks on a 3-bit counter build and a 3-input parity build.
module tb_tt_func_eval;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    tt_func_eval_if #(.N_IN(4)) bus0 ();
    tt_func_eval_if #(.N_IN(4)) bus1 ();
    tt_func_eval_if #(.N_IN(3)) bus2 ();
    logic        clr0, clr1, clr2;
    logic [15:0] cnt0;
    logic [2:0]  cnt1;
    logic [15:0] cnt2;

    tt_func_eval dut0 (.clk(clk), .rst(rst), .bus(bus0.slave), .cnt_clr(clr0), .hit_cnt(cnt0));
    tt_func_eval #(.CNT_W(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave), .cnt_clr(clr1), .hit_cnt(cnt1));
    tt_func_eval #(.N_IN(3), .DEFAULT_TT(8'h96)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave),
                                                       .cnt_clr(clr2), .hit_cnt(cnt2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference state for dut0, kept as spec-level quantities.
    logic [15:0] m_tt;
    logic        m_valid, m_f, m_busy;
    logic [3:0]  m_vec;
    int          m_cnt;
    bit          m_bits[$];

    task automatic model_reset();
        m_tt = 16'hB0A0; m_valid = 0; m_f = 0; m_vec = 0; m_cnt = 0; m_busy = 0;
        m_bits.delete();
    endtask

    task automatic drive0(input logic cs, cv, cb, iv, input logic [3:0] v, input logic ordy, clr);
        bus0.cfg_start = cs; bus0.cfg_valid = cv; bus0.cfg_bit = cb;
        bus0.in_valid = iv; bus0.in_vec = v; bus0.out_ready = ordy; clr0 = clr;
    endtask

    // One clock of dut0: check in_ready, advance the model across the edge, check outputs.
    task automatic tick0();
        logic acc, hs;
        logic [15:0] new_tt;
        #1;
        check("in_ready", bus0.in_ready, !m_valid || bus0.out_ready);
        acc = bus0.in_valid && (!m_valid || bus0.out_ready);
        hs  = m_valid && bus0.out_ready;
        @(posedge clk);
        if (clr0) m_cnt = 0;
        else if (hs && m_f && m_cnt < 65535) m_cnt++;
        new_tt = m_tt;
        if (m_busy) begin
            if (bus0.cfg_valid) begin
                m_bits.push_back(bus0.cfg_bit);
                if (m_bits.size() == 16) begin
                    for (int k = 0; k < 16; k++) new_tt[k] = m_bits[k];
                    m_busy = 0;
                    m_bits.delete();
                end
            end
        end else if (bus0.cfg_start) begin
            m_busy = 1;
            m_bits.delete();
        end
        if (acc) begin
            m_f = m_tt[bus0.in_vec]; m_vec = bus0.in_vec; m_valid = 1;
        end else if (bus0.out_ready) begin
            m_valid = 0;
        end
        m_tt = new_tt;
        #1;
        check("out_valid", bus0.out_valid, m_valid);
        check("cfg_busy", bus0.cfg_busy, m_busy);
        check("hit_cnt", cnt0, m_cnt);
        if (m_valid) begin
            check("out_f", bus0.out_f, m_f);
            check("out_vec", bus0.out_vec, m_vec);
        end
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        check("rst_busy", bus0.cfg_busy, 0);
        check("rst_valid", bus0.out_valid, 0);
        check("rst_f", bus0.out_f, 0);
        check("rst_vec", bus0.out_vec, 0);
        check("rst_cnt", cnt0, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] held_vec;
        logic       held_f;
        drive0(0, 0, 0, 0, 0, 0, 0);
        bus1.cfg_start = 0; bus1.cfg_valid = 0; bus1.cfg_bit = 0;
        bus1.in_valid = 0; bus1.in_vec = 0; bus1.out_ready = 0; clr1 = 0;
        bus2.cfg_start = 0; bus2.cfg_valid = 0; bus2.cfg_bit = 0;
        bus2.in_valid = 0; bus2.in_vec = 0; bus2.out_ready = 0; clr2 = 0;
        #2;
        async_reset();

        // Sweep all minterms against the default table.
        for (int v = 0; v < 16; v++) begin
            drive0(0, 0, 0, 1, 4'(v), 1, 0);
            tick0();
            check("sweep_f", bus0.out_f, v inside {5, 7, 12, 13, 15});
        end
        drive0(0, 0, 0, 0, 0, 1, 0);
        tick0();
        check("sweep_hits", cnt0, 5);

        // Load 16'h8000 with gaps; cfg_valid on the start cycle must be ignored.
        drive0(1, 1, 1, 0, 0, 1, 0);
        tick0();
        check("busy_start", bus0.cfg_busy, 1);
        for (int i = 0; i < 16; i++) begin
            if (i % 3 == 1) begin
                drive0(1, 0, 1, 0, 0, 1, 0);
                tick0();
                check("busy_gap", bus0.cfg_busy, 1);
            end
            drive0(0, 1, (i == 15), (i == 15), 4'd15, 1, 0);
            tick0();
            if (i == 15) check("commit_old_tt", bus0.out_f, 1);
            else         check("busy_load", bus0.cfg_busy, 1);
        end
        check("busy_done", bus0.cfg_busy, 0);
        drive0(0, 0, 0, 1, 4'd5, 1, 0);
        tick0();
        check("new_tt_5", bus0.out_f, 0);

        // Backpressure: hold a result for three cycles while another vector waits.
        drive0(0, 0, 0, 1, 4'd15, 1, 0);
        tick0();
        held_vec = bus0.out_vec;
        held_f   = bus0.out_f;
        for (int i = 0; i < 3; i++) begin
            drive0(0, 0, 0, 1, 4'd3, 0, 0);
            #1;
            check("stall_ready", bus0.in_ready, 0);
            tick0();
            check("stall_vec", bus0.out_vec, held_vec);
            check("stall_f", bus0.out_f, held_f);
        end
        drive0(0, 0, 0, 1, 4'd3, 1, 0);
        tick0();
        check("release_vec", bus0.out_vec, 3);
        drive0(0, 0, 0, 0, 0, 1, 0);
        tick0();

        // Reset in the middle of a load restores the default table.
        drive0(1, 0, 0, 0, 0, 1, 0);
        tick0();
        for (int i = 0; i < 6; i++) begin
            drive0(0, 1, 0, 0, 0, 1, 0);
            tick0();
        end
        async_reset();
        drive0(0, 0, 0, 1, 4'd13, 1, 0);
        tick0();
        check("post_rst_13", bus0.out_f, 1);

        // Randomised traffic with occasional loads, clears and backpressure.
        for (int c = 0; c < 3000; c++) begin
            drive0(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3) != 0, ($urandom_range(0, 99) == 0));
            tick0();
        end
        drive0(0, 0, 0, 0, 0, 1, 0);
        tick0();

        // Saturating 3-bit counter: nine hits end at 7, clear beats a hit.
        bus1.out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            bus1.in_valid = (i < 9);
            bus1.in_vec   = 4'd5;
            @(posedge clk); #1;
            check("sat_cnt", cnt1, (i < 7) ? i : 7);
        end
        bus1.in_valid = 1; bus1.in_vec = 4'd12;
        @(posedge clk); #1;
        check("sat_hold", cnt1, 7);
        bus1.in_valid = 0; clr1 = 1;
        @(posedge clk); #1;
        check("clr_wins", cnt1, 0);
        clr1 = 0;

        // Three-input parity table.
        bus2.out_ready = 1;
        for (int v = 0; v < 8; v++) begin
            bus2.in_valid = 1; bus2.in_vec = 3'(v);
            @(posedge clk); #1;
            check("parity_f", bus2.out_f, $countones(v) % 2);
            check("parity_vec", bus2.out_vec, v);
        end
        bus2.in_valid = 0;
        @(posedge clk); #1;
        check("parity_hits", cnt2, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
